button_debouncer: RTL and testbench

Two-channel synchronizer and debouncer for the board push-buttons/switches that drive the `a` and `b` inputs of the `or_gate` stage. Each raw asynchronous input is synchronized into the `clk` domain, then filtered so that only a level held stable for `STABLE_CYCLES` clocks propagates. The output is a clean level per channel plus single-cycle rise/fall strobes. `btn_db[0]` and `btn_db[1]` connect directly to `or_gate.a` and `or_gate.b`.

---
 rtl/dsd_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/button_debouncer.sv | 31 +++
 tb/tb_button_debouncer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dsd_pkg.sv
// Shared constants, state encoding and helpers for the board-input debounce logic.
package dsd_pkg;

   localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;
   localparam int unsigned CLK_HZ                = 100000000;

   typedef enum logic {
      DB_IDLE,
      DB_QUAL
   } db_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One-bit synchronizer and debouncer: level follows the input only after it
// has differed from the output for STABLE_CYCLES consecutive clocks.
module debounce_channel
   import dsd_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
)(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int unsigned      CNT_W    = (clog2(STABLE_CYCLES) < 1) ? 1 : clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_s1;
   logic             r_s2;
   logic             r_db;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;
   db_state_t        r_state;

   db_state_t        w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_db_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             w_deviate;

   assign w_deviate = (r_s2 != r_db);

   // STABLE_CYCLES >= 2, so the first deviating edge can never be terminal.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_db_nxt    = r_db;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         DB_IDLE: begin
            if (w_deviate) begin
               w_state_nxt = DB_QUAL;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         DB_QUAL: begin
            if (!w_deviate) begin
               w_state_nxt = DB_IDLE;
            end else if (r_cnt == CNT_TERM) begin
               w_state_nxt = DB_IDLE;
               w_db_nxt    = r_s2;
               w_rise_nxt  = r_s2;
               w_fall_nxt  = ~r_s2;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = DB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_cnt   <= '0;
         r_db    <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_state <= DB_IDLE;
      end else begin
         r_s1    <= din;
         r_s2    <= r_s1;
         r_cnt   <= w_cnt_nxt;
         r_db    <= w_db_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign dout = r_db;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = (r_cnt != '0);

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer; btn_db[1:0] feed or_gate.a / or_gate.b.
module button_debouncer
   import dsd_pkg::*;
#(
   parameter int unsigned N_CH          = 2,
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_db,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] busy
);

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .din  (btn_raw[g]),
         .dout (btn_db[g]),
         .rise (btn_rise[g]),
         .fall (btn_fall[g]),
         .busy (busy[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with N_CH=2, STABLE_CYCLES=4.
module tb_button_debouncer;

   logic       clk;
   logic       rst;
   logic [1:0] btn_raw;
   logic [1:0] btn_db;
   logic [1:0] btn_rise;
   logic [1:0] btn_fall;
   logic [1:0] busy;

   int unsigned n_checks;
   int unsigned n_fail;

   button_debouncer #(
      .N_CH          (2),
      .STABLE_CYCLES (4)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs, advance one rising edge, then compare all outputs.
   task automatic cyc(input string tag, input logic r, input logic [1:0] raw,
                      input logic [1:0] e_db, input logic [1:0] e_rise,
                      input logic [1:0] e_fall, input logic [1:0] e_busy);
      rst     = r;
      btn_raw = raw;
      @(posedge clk);
      #1;
      check({tag, ".db"},   32'(btn_db),   32'(e_db));
      check({tag, ".rise"}, 32'(btn_rise), 32'(e_rise));
      check({tag, ".fall"}, 32'(btn_fall), 32'(e_fall));
      check({tag, ".busy"}, 32'(busy),     32'(e_busy));
   endtask

   // Clean change held for n calls: busy on calls 3..5, output and strobe on call 6.
   task automatic settle(input string tag, input logic [1:0] raw, input logic [1:0] db_old,
                         input logic [1:0] db_new, input int unsigned n);
      logic [1:0] m;
      m = db_old ^ db_new;
      for (int unsigned i = 1; i <= n; i++) begin
         cyc(tag, 1'b0, raw,
             (i >= 6) ? db_new : db_old,
             (i == 6) ? (m & db_new) : 2'b00,
             (i == 6) ? (m & ~db_new) : 2'b00,
             (i >= 3 && i <= 5) ? m : 2'b00);
      end
   endtask

   initial begin
      logic [1:12] p_raw;
      logic [1:12] p_db;
      logic [1:12] p_rise;
      logic [1:12] p_fall;
      logic [1:12] p_busy;
      logic [1:8]  q_raw;
      logic [1:8]  q_busy;

      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      btn_raw  = 2'b11;

      for (int unsigned i = 0; i < 3; i++) begin
         cyc("reset", 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      settle("rst_rel", 2'b11, 2'b00, 2'b11, 7);
      settle("rel_both", 2'b00, 2'b11, 2'b00, 7);

      settle("press0", 2'b01, 2'b00, 2'b01, 10);
      settle("release0", 2'b00, 2'b01, 2'b00, 7);

      for (int unsigned k = 1; k <= 3; k++) begin
         for (int unsigned i = 1; i <= k + 5; i++) begin
            cyc("glitch1", 1'b0, (i <= k) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00,
                (i >= 3 && i <= k + 2) ? 2'b10 : 2'b00);
         end
      end

      p_raw  = 12'b111100000000;
      p_db   = 12'b000001111000;
      p_rise = 12'b000001000000;
      p_fall = 12'b000000000100;
      p_busy = 12'b001110111000;
      for (int unsigned i = 1; i <= 12; i++) begin
         cyc("pulse4", 1'b0, {p_raw[i], 1'b0}, {p_db[i], 1'b0}, {p_rise[i], 1'b0},
             {p_fall[i], 1'b0}, {p_busy[i], 1'b0});
      end

      p_raw  = 12'b101101111111;
      p_db   = 12'b000000000011;
      p_rise = 12'b000000000010;
      p_busy = 12'b001011011100;
      for (int unsigned i = 1; i <= 12; i++) begin
         cyc("bounce0", 1'b0, {1'b0, p_raw[i]}, {1'b0, p_db[i]}, {1'b0, p_rise[i]},
             2'b00, {1'b0, p_busy[i]});
      end

      settle("indep_rel", 2'b00, 2'b01, 2'b00, 7);
      settle("indep_both", 2'b11, 2'b00, 2'b11, 7);
      q_raw  = 8'b01010111;
      q_busy = 8'b00101010;
      for (int unsigned i = 1; i <= 8; i++) begin
         cyc("bounce1", 1'b0, {q_raw[i], 1'b1}, 2'b11, 2'b00, 2'b00, {q_busy[i], 1'b0});
      end
      settle("indep_fall", 2'b00, 2'b11, 2'b00, 7);

      cyc("midq", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      cyc("midq", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      cyc("midq", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      cyc("midq", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      cyc("midq_rst", 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      settle("midq_requal", 2'b01, 2'b00, 2'b01, 7);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
